mem_access_sequencer: RTL

- Sits between the SLC-3 datapath/ISDU and the SRAM/Mem2IO side.
- Owns the active-low SRAM strobes (CE, UB, LB, OE, WE) and sequences each single-word read or write as a timed setup/access/done handshake.
- Arbitrates the memory between two requesters: the CPU (MAR/MDR path) and a debug/loader port that pokes program words from the switches.

---
 rtl/mem_seq_pkg.sv | 40 ++++
 rtl/rr_arbiter2.sv | 52 +++++
 rtl/mem_access_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// -----------------------------------------------------------------------------
// mem_seq_pkg
// Shared types and constants for the SRAM access sequencer.
//   - state_e     : sequencer FSM states (IDLE, SETUP, ACCESS, DONE)
//   - req_id_e    : requester identity (REQ_CPU, REQ_DBG)
//   - strobes_t   : active-low SRAM strobe bundle {ce, ub, lb, oe, we}
//   - STROBE_IDLE : all strobes deasserted (all ones)
//   - ADDR_W_DEFAULT / DATA_W_DEFAULT : default bus widths
// -----------------------------------------------------------------------------
package mem_seq_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 20;
  localparam int unsigned DATA_W_DEFAULT = 16;

  // Wide enough for the largest legal access phase (15 cycles).
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

  typedef struct packed {
    logic ce;
    logic ub;
    logic lb;
    logic oe;
    logic we;
  } strobes_t;

  localparam strobes_t STROBE_IDLE = 5'b11111;

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin arbiter with a last-grant register. The grant output
// is combinational from the requests and the last-grant register; the register
// advances only when en_i pulses (the sequencer's IDLE grant edge).
// Only built when MEM_SEQ_DBG_PORT_EN is defined; without the debug port the
// sequencer always grants the CPU and has no arbiter.
//
// Ports:
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset (CPU wins the first tie)
//   req_cpu_i  : CPU request
//   req_dbg_i  : debug/loader request
//   en_i       : commit the current grant as the last grant
//   gnt_o      : granted requester (REQ_CPU when neither requests)
// -----------------------------------------------------------------------------
`ifdef MEM_SEQ_DBG_PORT_EN
module rr_arbiter2
  import mem_seq_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    req_cpu_i,
  input  logic    req_dbg_i,
  input  logic    en_i,
  output req_id_e gnt_o
);

  req_id_e last_q, last_d;

  always_comb begin
    gnt_o = REQ_CPU;
    if (req_cpu_i && req_dbg_i) begin
      // Tie: favour whoever was not served last.
      gnt_o = (last_q == REQ_CPU) ? REQ_DBG : REQ_CPU;
    end else if (req_dbg_i) begin
      gnt_o = REQ_DBG;
    end
    last_d = en_i ? gnt_o : last_q;
  end

  // Resetting to "DBG served last" makes the CPU win the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= REQ_DBG;
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`endif

// File: rtl/mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// mem_access_sequencer
// Sequences single-word SRAM reads and writes for the SLC-3 as a
// SETUP / ACCESS (WAIT_CYCLES) / DONE handshake and owns the active-low SRAM
// strobes. Two requesters share the memory: the CPU (MAR/MDR path) and a
// debug/loader port.
//
// Build option: MEM_SEQ_DBG_PORT_EN
//   defined   : debug port live, round-robin arbitration between CPU and debug.
//   undefined : dbg_* inputs ignored, dbg_ack/dbg_rdata tied to 0, CPU always
//               granted. The port list is the same in both builds.
//
// Ports:
//   Clk, Reset          : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata : CPU request (req held until cpu_ack)
//   cpu_ack, cpu_rdata    : one-cycle completion pulse, held read data
//   dbg_*                 : same as the CPU port, for the debug/loader
//   ADDR, Data_out        : SRAM address and write data
//   Data_drive            : 1 = Data_out drives the shared data bus
//   Data_in               : SRAM read data
//   CE, UB, LB, OE, WE    : SRAM strobes, active-low
//
// Timing (W = WAIT_CYCLES): grant edge -> 1 SETUP cycle -> W ACCESS cycles ->
// 1 DONE cycle (ack) -> at least 1 IDLE cycle before the next grant.
// -----------------------------------------------------------------------------
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W      = DATA_W_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_drive,
  input  logic [DATA_W-1:0] Data_in,

  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // State and latched transaction
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  req_id_e             gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;

  // Arbitration result and the selected requester's fields.
  logic                any_req;
  logic                grant_en;
  req_id_e             arb_gnt;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  strobes_t            strb;

`ifdef MEM_SEQ_DBG_PORT_EN
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;

  assign any_req = cpu_req | dbg_req;

  rr_arbiter2 u_arb (
    .clk_i     (Clk),
    .rst_ni    (Reset),
    .req_cpu_i (cpu_req),
    .req_dbg_i (dbg_req),
    .en_i      (grant_en),
    .gnt_o     (arb_gnt)
  );
`else
  // Debug inputs are intentionally unused in this build.
  logic unused_dbg;
  assign unused_dbg = ^{dbg_req, dbg_we, dbg_addr, dbg_wdata};

  assign any_req = cpu_req;
  assign arb_gnt = REQ_CPU;
`endif

  // A grant happens only on an IDLE edge; this also steps the arbiter.
  assign grant_en = (state_q == IDLE) && any_req;

  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
`ifdef MEM_SEQ_DBG_PORT_EN
    if (arb_gnt == REQ_DBG) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a hold/default value before the case so that no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
`ifdef MEM_SEQ_DBG_PORT_EN
    dbg_rdata_d = dbg_rdata_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_en) begin
          // Everything the transaction needs is captured here, so requester
          // inputs may change freely until the ack.
          state_d = SETUP;
          gnt_d   = arb_gnt;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
        end
      end

      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CNT_LOAD;
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          // Final ACCESS edge: OE has been low for the whole access phase.
          if (!we_q) begin
`ifdef MEM_SEQ_DBG_PORT_EN
            if (gnt_q == REQ_DBG) begin
              dbg_rdata_d = Data_in;
            end else begin
              cpu_rdata_d = Data_in;
            end
`else
            cpu_rdata_d = Data_in;
`endif
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      gnt_q       <= REQ_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

`ifdef MEM_SEQ_DBG_PORT_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      dbg_rdata_q <= '0;
    end else begin
      dbg_rdata_q <= dbg_rdata_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs: decoded only from registers, so there is no combinational path
  // from any request to the strobes, and an async reset of state_q releases
  // the bus immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    strb       = STROBE_IDLE;
    Data_drive = 1'b0;

    unique case (state_q)
      SETUP: begin
        strb.ce = 1'b0;
        strb.ub = 1'b0;
        strb.lb = 1'b0;
        if (we_q) begin
          Data_drive = 1'b1;
        end else begin
          strb.oe = 1'b0;
        end
      end

      ACCESS: begin
        strb.ce = 1'b0;
        strb.ub = 1'b0;
        strb.lb = 1'b0;
        if (we_q) begin
          strb.we    = 1'b0;
          Data_drive = 1'b1;
        end else begin
          strb.oe = 1'b0;
        end
      end

      DONE: begin
        // WE (or OE) has already risen; chip stays selected and write data
        // stays on the bus for one hold cycle.
        strb.ce = 1'b0;
        strb.ub = 1'b0;
        strb.lb = 1'b0;
        if (we_q) begin
          Data_drive = 1'b1;
        end
      end

      default: begin
        strb       = STROBE_IDLE;
        Data_drive = 1'b0;
      end
    endcase
  end

  assign CE       = strb.ce;
  assign UB       = strb.ub;
  assign LB       = strb.lb;
  assign OE       = strb.oe;
  assign WE       = strb.we;
  assign ADDR     = addr_q;
  assign Data_out = wdata_q;

  assign cpu_ack   = (state_q == DONE) && (gnt_q == REQ_CPU);
  assign cpu_rdata = cpu_rdata_q;

`ifdef MEM_SEQ_DBG_PORT_EN
  assign dbg_ack   = (state_q == DONE) && (gnt_q == REQ_DBG);
  assign dbg_rdata = dbg_rdata_q;
`else
  assign dbg_ack   = 1'b0;
  assign dbg_rdata = '0;
`endif

endmodule
